// File: rtl/hazard_scheduler_if.sv
// Hazard scheduler bus: decode-stage instruction fields in, pipeline
// control (stall/bubble/flush/forward selects) and perf counters out.
interface hazard_scheduler_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       rs_d;
   logic [4:0]       rt_d;
   logic             use_rs_d;
   logic             use_rt_d;
   logic [4:0]       dest_d;
   logic             wr_d;
   logic             load_d;
   logic             branch_d;
   logic             jump_d;
   logic             br_taken_x;
   logic             stall_f;
   logic             bubble_d;
   logic             flush_f;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   // Pipeline side: presents the ID instruction, consumes the controls.
   modport master (
      output rs_d, rt_d, use_rs_d, use_rt_d, dest_d, wr_d, load_d,
             branch_d, jump_d, br_taken_x,
      input  stall_f, bubble_d, flush_f, fwd_a, fwd_b, stall_cnt, flush_cnt
   );

   // Scheduler side.
   modport slave (
      input  rs_d, rt_d, use_rs_d, use_rt_d, dest_d, wr_d, load_d,
             branch_d, jump_d, br_taken_x,
      output stall_f, bubble_d, flush_f, fwd_a, fwd_b, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_scheduler.sv
// Hazard controller for the five-stage pipeline: tracks in-flight writers
// in an EX/MEM/WB scoreboard, selects ALU operand forwarding, stalls on
// load-use, flushes after jumps and taken branches, and counts stall/flush
// cycles with saturating counters.
module hazard_scheduler #(
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   hazard_scheduler_if.slave sched
);

   typedef enum logic {
      RUN   = 1'b0,
      BR_EX = 1'b1
   } state_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] dest;
      logic       load;
   } sb_entry_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q, state_d;
   sb_entry_t        ex_q, ex_d;
   sb_entry_t        mem_q, mem_d;
   sb_entry_t        wb_q, wb_d;
   logic [4:0]       rs_x_q, rs_x_d;
   logic [4:0]       rt_x_q, rt_x_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic             load_use;
   logic             br_taken;
   logic             stall;
   logic             bubble;
   logic             flush;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;

   // Decide stall/bubble/flush; a taken branch wins over load-use and jumps
   // because the ID instruction it would protect is being discarded anyway.
   always_comb begin
      load_use = ex_q.valid & ex_q.load &
                 ((sched.use_rs_d & (ex_q.dest == sched.rs_d)) |
                  (sched.use_rt_d & (ex_q.dest == sched.rt_d)));
      br_taken = (state_q == BR_EX) & sched.br_taken_x;
      stall    = load_use & ~br_taken;
      bubble   = load_use | br_taken;
      flush    = br_taken | (sched.jump_d & ~stall);
   end

   // Operand forwarding for the EX instruction; the younger MEM result wins.
   always_comb begin
      fwd_a = FWD_RF;
      if (mem_q.valid && (mem_q.dest == rs_x_q)) begin
         fwd_a = FWD_MEM;
      end else if (wb_q.valid && (wb_q.dest == rs_x_q)) begin
         fwd_a = FWD_WB;
      end
      fwd_b = FWD_RF;
      if (mem_q.valid && (mem_q.dest == rt_x_q)) begin
         fwd_b = FWD_MEM;
      end else if (wb_q.valid && (wb_q.dest == rt_x_q)) begin
         fwd_b = FWD_WB;
      end
   end

   // Next-state: branch FSM, scoreboard shift, EX sources, saturating counters.
   always_comb begin
      state_d = RUN;
      if (!br_taken && sched.branch_d && !stall) begin
         state_d = BR_EX;
      end

      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = '0;
      if (!bubble) begin
         ex_d.valid = sched.wr_d & (sched.dest_d != 5'd0);
         ex_d.dest  = sched.dest_d;
         ex_d.load  = sched.load_d;
      end

      rs_x_d = sched.rs_d;
      rt_x_d = sched.rt_d;

      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
      flush_cnt_d = flush_cnt_q;
      if (flush && (flush_cnt_q != CNT_MAX)) begin
         flush_cnt_d = flush_cnt_q + 1'b1;
      end
   end

   // State registers, cleared asynchronously by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= RUN;
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         rs_x_q      <= '0;
         rt_x_q      <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         ex_q        <= ex_d;
         mem_q       <= mem_d;
         wb_q        <= wb_d;
         rs_x_q      <= rs_x_d;
         rt_x_q      <= rt_x_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Controls are held at their idle value while reset is asserted so a
   // stray jump or branch input cannot leak through during reset.
   assign sched.stall_f   = stall & ~reset;
   assign sched.bubble_d  = bubble & ~reset;
   assign sched.flush_f   = flush & ~reset;
   assign sched.fwd_a     = fwd_a & {2{~reset}};
   assign sched.fwd_b     = fwd_b & {2{~reset}};
   assign sched.stall_cnt = stall_cnt_q;
   assign sched.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler: drives decode-stage instruction
// fields cycle by cycle and compares the controls with hand-derived values.
module tb_hazard_scheduler;

   localparam int CNT_W = 16;

   logic clk;
   logic reset;
   int   compare_count;
   int   mismatch_count;

   hazard_scheduler_if #(.CNT_W(CNT_W)) dut_if ();
   hazard_scheduler_if #(.CNT_W(2))     sat_if ();

   hazard_scheduler #(.CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .sched (dut_if.slave)
   );

   // Narrow-counter copy fed with identical inputs to reach saturation.
   hazard_scheduler #(.CNT_W(2)) sat_dut (
      .clk   (clk),
      .reset (reset),
      .sched (sat_if.slave)
   );

   assign sat_if.rs_d       = dut_if.rs_d;
   assign sat_if.rt_d       = dut_if.rt_d;
   assign sat_if.use_rs_d   = dut_if.use_rs_d;
   assign sat_if.use_rt_d   = dut_if.use_rt_d;
   assign sat_if.dest_d     = dut_if.dest_d;
   assign sat_if.wr_d       = dut_if.wr_d;
   assign sat_if.load_d     = dut_if.load_d;
   assign sat_if.branch_d   = dut_if.branch_d;
   assign sat_if.jump_d     = dut_if.jump_d;
   assign sat_if.br_taken_x = dut_if.br_taken_x;

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt,
                                input logic use_rs, input logic use_rt,
                                input logic [4:0] dest, input logic wr,
                                input logic load, input logic branch,
                                input logic jump, input logic taken);
      dut_if.rs_d       = rs;
      dut_if.rt_d       = rt;
      dut_if.use_rs_d   = use_rs;
      dut_if.use_rt_d   = use_rt;
      dut_if.dest_d     = dest;
      dut_if.wr_d       = wr;
      dut_if.load_d     = load;
      dut_if.branch_d   = branch;
      dut_if.jump_d     = jump;
      dut_if.br_taken_x = taken;
      #1;
   endtask

   task automatic idle(input logic taken);
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, taken);
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compare_count++;
      if (observed !== expected) begin
         mismatch_count++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic checkControl(input string tag, input logic s, input logic b,
                               input logic f);
      checkOutput({tag, ".stall_f"},  32'(dut_if.stall_f),  32'(s));
      checkOutput({tag, ".bubble_d"}, 32'(dut_if.bubble_d), 32'(b));
      checkOutput({tag, ".flush_f"},  32'(dut_if.flush_f),  32'(f));
   endtask

   task automatic checkFwd(input string tag, input logic [1:0] a, input logic [1:0] b);
      checkOutput({tag, ".fwd_a"}, 32'(dut_if.fwd_a), 32'(a));
      checkOutput({tag, ".fwd_b"}, 32'(dut_if.fwd_b), 32'(b));
   endtask

   task automatic checkCounts(input string tag, input int s, input int f);
      checkOutput({tag, ".stall_cnt"}, 32'(dut_if.stall_cnt), 32'(s));
      checkOutput({tag, ".flush_cnt"}, 32'(dut_if.flush_cnt), 32'(f));
   endtask

   initial begin
      compare_count  = 0;
      mismatch_count = 0;

      reset = 1'b1;
      idle(1'b0);
      #1;
      checkControl("reset", 1'b0, 1'b0, 1'b0);
      checkFwd("reset", 2'b00, 2'b00);
      checkCounts("reset", 0, 0);
      @(posedge clk);
      #2;
      reset = 1'b0;

      // ALU chain: add r3<-r1,r2 ; sub r5<-r3,r4 forwards from MEM
      applyStimulus(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checkControl("alu.add", 1'b0, 1'b0, 1'b0);
      nextCycle();
      applyStimulus(5'd3, 5'd4, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checkControl("alu.sub", 1'b0, 1'b0, 1'b0);
      nextCycle();
      idle(1'b0);
      checkFwd("alu.near", 2'b01, 2'b00);
      nextCycle();

      // One independent instruction between writer and reader: WB forward
      applyStimulus(5'd1, 5'd2, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      nextCycle();
      applyStimulus(5'd8, 5'd9, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      nextCycle();
      applyStimulus(5'd6, 5'd4, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checkControl("alu.far", 1'b0, 1'b0, 1'b0);
      nextCycle();
      idle(1'b0);
      checkFwd("alu.far", 2'b10, 2'b00);
      nextCycle();
      idle(1'b0); nextCycle();
      idle(1'b0); nextCycle();

      // Load-use: lw r2 ; add r4<-r2,r2 stalls once then reads WB
      applyStimulus(5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      checkControl("lu.lw", 1'b0, 1'b0, 1'b0);
      nextCycle();
      applyStimulus(5'd2, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checkControl("lu.hit", 1'b1, 1'b1, 1'b0);
      checkCounts("lu.before", 0, 0);
      nextCycle();
      applyStimulus(5'd2, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checkControl("lu.held", 1'b0, 1'b0, 1'b0);
      checkCounts("lu.after", 1, 0);
      nextCycle();
      idle(1'b0);
      checkFwd("lu.fwd", 2'b10, 2'b10);
      nextCycle();
      idle(1'b0); nextCycle();
      idle(1'b0); nextCycle();

      // Load into r0 then use r0: neither stall nor forward
      applyStimulus(5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      nextCycle();
      applyStimulus(5'd0, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checkControl("r0.use", 1'b0, 1'b0, 1'b0);
      nextCycle();
      idle(1'b0);
      checkFwd("r0.mem", 2'b00, 2'b00);
      nextCycle();
      idle(1'b0); nextCycle();
      idle(1'b0); nextCycle();

      // Taken branch while a load-use hazard and a jump sit in ID
      applyStimulus(5'd8, 5'd9, 1'b1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      checkControl("tk.beq", 1'b0, 1'b0, 1'b0);
      nextCycle();
      applyStimulus(5'd2, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      checkControl("tk.taken", 1'b0, 1'b1, 1'b1);
      checkCounts("tk.before", 1, 0);
      nextCycle();
      idle(1'b1);
      checkControl("tk.run", 1'b0, 1'b0, 1'b0);
      checkCounts("tk.after", 1, 1);
      nextCycle();

      // Reset pulse while in BR_EX with a live scoreboard
      applyStimulus(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      nextCycle();
      applyStimulus(5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      nextCycle();
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      checkControl("rst.pre", 1'b0, 1'b1, 1'b1);
      checkFwd("rst.pre", 2'b01, 2'b00);
      reset = 1'b1;
      #1;
      checkControl("rst.async", 1'b0, 1'b0, 1'b0);
      checkFwd("rst.async", 2'b00, 2'b00);
      checkCounts("rst.async", 0, 0);
      #1;
      reset = 1'b0;
      idle(1'b1);
      checkControl("rst.run", 1'b0, 1'b0, 1'b0);
      nextCycle();
      applyStimulus(5'd3, 5'd3, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      nextCycle();
      idle(1'b0);
      checkFwd("rst.stale", 2'b00, 2'b00);
      nextCycle();
      applyStimulus(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      nextCycle();
      applyStimulus(5'd3, 5'd3, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      nextCycle();
      idle(1'b0);
      checkFwd("rst.fresh", 2'b01, 2'b01);
      nextCycle();
      idle(1'b0); nextCycle();
      idle(1'b0); nextCycle();

      // Jump, then a not-taken beq
      applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkControl("jmp", 1'b0, 1'b0, 1'b1);
      checkCounts("jmp.before", 0, 0);
      nextCycle();
      applyStimulus(5'd4, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checkControl("nt.beq", 1'b0, 1'b0, 1'b0);
      nextCycle();
      idle(1'b0);
      checkControl("nt.resolve", 1'b0, 1'b0, 1'b0);
      checkCounts("nt.after", 0, 1);
      nextCycle();

      // Back-to-back branches: not-taken then taken
      applyStimulus(5'd4, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      nextCycle();
      applyStimulus(5'd6, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checkControl("b2b.first", 1'b0, 1'b0, 1'b0);
      nextCycle();
      idle(1'b1);
      checkControl("b2b.second", 1'b0, 1'b1, 1'b1);
      nextCycle();
      idle(1'b1);
      checkControl("b2b.done", 1'b0, 1'b0, 1'b0);
      checkCounts("b2b", 0, 2);
      nextCycle();

      // Five more jumps: wide counter reaches 7, 2-bit counter holds at 3
      for (int i = 0; i < 5; i++) begin
         applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         nextCycle();
      end
      idle(1'b0);
      checkOutput("sat.wide.flush_cnt", 32'(dut_if.flush_cnt), 32'd7);
      checkOutput("sat.narrow.flush_cnt", 32'(sat_if.flush_cnt), 32'd3);
      checkOutput("sat.narrow.stall_cnt", 32'(sat_if.stall_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
      $finish;
   end

endmodule
